// File: rtl/block_ram_controller.sv
// Valid/ready bus responder in front of a single-port-read/single-port-write block RAM.
// Byte-strobe writes are done as read-modify-write; bad addresses never touch the RAM.
module block_ram_controller #(
  parameter int unsigned SIZE      = 1024,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 32,
  localparam int unsigned NB       = WIDTH / 8,
  localparam int unsigned AW       = $clog2(SIZE / NB)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_write,
  input  logic [ADDR_BITS-1:0] i_req_address,
  input  logic [WIDTH-1:0]     i_req_wdata,
  input  logic [NB-1:0]        i_req_wstrb,
  output logic                 o_resp_valid,
  input  logic                 i_resp_ready,
  output logic [WIDTH-1:0]     o_resp_rdata,
  output logic                 o_resp_error,
  output logic                 o_ram_write_en,
  output logic [AW-1:0]        o_ram_write_address,
  output logic [WIDTH-1:0]     o_ram_write_data,
  output logic [AW-1:0]        o_ram_read_address,
  input  logic [WIDTH-1:0]     i_ram_read_data
);

  localparam int unsigned OB = $clog2(NB);
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ADDR_BITS'((64'd1 << OB) - 64'd1);

  typedef enum logic [1:0] {StIdle, StRdWait, StWrite, StResp} state_e;

  state_e            r_state, w_state_next;
  logic              r_write, w_write_next;
  logic [AW-1:0]     r_index, w_index_next;
  logic [WIDTH-1:0]  r_wdata, w_wdata_next;
  logic [NB-1:0]     r_wstrb, w_wstrb_next;
  logic [WIDTH-1:0]  r_rdata, w_rdata_next;
  logic              r_error, w_error_next;

  logic              w_accept;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic [AW-1:0]     w_index;

  assign w_misaligned   = |(i_req_address & ALIGN_MASK);
  assign w_out_of_range = i_req_address >= ADDR_BITS'(SIZE);
  assign w_index        = AW'(i_req_address >> OB);
  assign w_accept       = i_req_valid && o_req_ready;

  always_comb begin
    w_state_next = r_state;
    w_write_next = r_write;
    w_index_next = r_index;
    w_wdata_next = r_wdata;
    w_wstrb_next = r_wstrb;
    w_rdata_next = r_rdata;
    w_error_next = r_error;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_write_next = i_req_write;
          w_index_next = w_index;
          w_wdata_next = i_req_wdata;
          w_wstrb_next = i_req_wstrb;
          if (w_misaligned || w_out_of_range) begin
            w_error_next = 1'b1;
            w_state_next = StResp;
          end else if (!i_req_write) begin
            w_state_next = StRdWait;
          end else if (&i_req_wstrb) begin
            w_state_next = StWrite;
          end else if (~|i_req_wstrb) begin
            w_state_next = StResp;
          end else begin
            // Partial strobe: fetch the old word first so it can be merged.
            w_state_next = StRdWait;
          end
        end
      end
      StRdWait: begin
        if (r_write) begin
          for (int b = 0; b < int'(NB); b++) begin
            w_wdata_next[8*b +: 8] = r_wstrb[b] ? r_wdata[8*b +: 8] : i_ram_read_data[8*b +: 8];
          end
          w_state_next = StWrite;
        end else begin
          w_rdata_next = i_ram_read_data;
          w_state_next = StResp;
        end
      end
      StWrite: w_state_next = StResp;
      StResp: begin
        if (i_resp_ready) begin
          w_rdata_next = '0;
          w_error_next = 1'b0;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_write <= 1'b0;
      r_index <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_write <= w_write_next;
      r_index <= w_index_next;
      r_wdata <= w_wdata_next;
      r_wstrb <= w_wstrb_next;
      r_rdata <= w_rdata_next;
      r_error <= w_error_next;
    end
  end

  assign o_req_ready         = (r_state == StIdle) && !reset;
  assign o_resp_valid        = (r_state == StResp);
  assign o_resp_rdata        = r_rdata;
  assign o_resp_error        = r_error;
  assign o_ram_write_en      = (r_state == StWrite);
  assign o_ram_write_address = r_index;
  assign o_ram_write_data    = r_wdata;
  // The RAM samples the live address on the accept edge, so RD_WAIT already has data.
  assign o_ram_read_address  = (r_state == StIdle) ? w_index : r_index;

endmodule

// File: tb/tb_block_ram_controller.sv
// Directed bench for block_ram_controller with a behavioural block RAM (1-cycle read latency).
module tb_block_ram_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_address = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        ram_we;
  logic [7:0]  ram_waddr;
  logic [31:0] ram_wdata;
  logic [7:0]  ram_raddr;
  logic [31:0] ram_rdata = '0;

  logic [31:0] mem [256];
  int          wr_pulses = 0;
  logic [7:0]  last_waddr = '0;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  block_ram_controller #(.SIZE(1024), .WIDTH(32), .ADDR_BITS(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_req_valid         (req_valid),
    .o_req_ready         (req_ready),
    .i_req_write         (req_write),
    .i_req_address       (req_address),
    .i_req_wdata         (req_wdata),
    .i_req_wstrb         (req_wstrb),
    .o_resp_valid        (resp_valid),
    .i_resp_ready        (resp_ready),
    .o_resp_rdata        (resp_rdata),
    .o_resp_error        (resp_error),
    .o_ram_write_en      (ram_we),
    .o_ram_write_address (ram_waddr),
    .o_ram_write_data    (ram_wdata),
    .o_ram_read_address  (ram_raddr),
    .i_ram_read_data     (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
      wr_pulses      <= wr_pulses + 1;
      last_waddr     <= ram_waddr;
    end
    ram_rdata <= mem[ram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Wait for resp_valid; edges counts clock edges from the accept edge inclusive.
  task automatic wait_resp(output int edges);
    edges = 1;
    while (!resp_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int edges, output logic [31:0] rd,
                      output logic er, output int pulses);
    int p0;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    resp_ready  = 1'b1;
    req_valid   = 1'b1;
    req_write   = wr;
    req_address = a;
    req_wdata   = d;
    req_wstrb   = s;
    p0 = wr_pulses;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(edges);
    rd     = resp_rdata;
    er     = resp_error;
    pulses = wr_pulses - p0;
  endtask

  initial begin
    int          edges;
    int          pulses;
    int          p0;
    logic [31:0] rd;
    logic        er;

    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    #2;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_write_en", {31'd0, ram_we}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Full-strobe write then read
    xact(1'b1, 32'h010, 32'hDEADBEEF, 4'hF, edges, rd, er, pulses);
    chk("fw_edges", edges, 2);
    chk("fw_error", {31'd0, er}, 32'd0);
    chk("fw_rdata", rd, 32'd0);
    chk("fw_pulses", pulses, 1);
    chk("fw_index", {24'd0, last_waddr}, 32'd4);
    xact(1'b0, 32'h010, 32'h0, 4'h0, edges, rd, er, pulses);
    chk("rd1_edges", edges, 2);
    chk("rd1_rdata", rd, 32'hDEADBEEF);
    chk("rd1_error", {31'd0, er}, 32'd0);

    // Partial write merges bytes 1 and 2
    xact(1'b1, 32'h010, 32'h00AA5500, 4'h6, edges, rd, er, pulses);
    chk("pw_edges", edges, 3);
    chk("pw_pulses", pulses, 1);
    chk("pw_error", {31'd0, er}, 32'd0);
    xact(1'b0, 32'h010, 32'h0, 4'h0, edges, rd, er, pulses);
    chk("pw_readback", rd, 32'hDEAA55EF);

    // Misaligned read and out-of-range write
    xact(1'b0, 32'h012, 32'h0, 4'h0, edges, rd, er, pulses);
    chk("mis_edges", edges, 1);
    chk("mis_error", {31'd0, er}, 32'd1);
    chk("mis_rdata", rd, 32'd0);
    chk("mis_pulses", pulses, 0);
    xact(1'b1, 32'h400, 32'h12345678, 4'hF, edges, rd, er, pulses);
    chk("oor_edges", edges, 1);
    chk("oor_error", {31'd0, er}, 32'd1);
    chk("oor_rdata", rd, 32'd0);
    chk("oor_pulses", pulses, 0);

    // Response backpressure with a queued request held on req_valid
    @(negedge clk);
    resp_ready  = 1'b0;
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_address = 32'h010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(edges);
    chk("bp_edges", edges, 2);
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_address = 32'h014;
    req_wdata   = 32'h11223344;
    req_wstrb   = 4'hF;
    p0 = wr_pulses;
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_rdata", resp_rdata, 32'hDEAA55EF);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("bp_no_accept", wr_pulses - p0, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_req_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_hs_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("bp_hs_rdata", resp_rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(edges);
    chk("bp_next_edges", edges, 2);
    chk("bp_next_pulses", wr_pulses - p0, 1);
    chk("bp_next_index", {24'd0, last_waddr}, 32'd5);
    xact(1'b0, 32'h014, 32'h0, 4'h0, edges, rd, er, pulses);
    chk("bp_next_readback", rd, 32'h11223344);

    // Zero strobe write leaves memory alone
    xact(1'b1, 32'h010, 32'h55555555, 4'h0, edges, rd, er, pulses);
    chk("zs_edges", edges, 1);
    chk("zs_pulses", pulses, 0);
    chk("zs_error", {31'd0, er}, 32'd0);
    xact(1'b0, 32'h010, 32'h0, 4'h0, edges, rd, er, pulses);
    chk("zs_readback", rd, 32'hDEAA55EF);

    // Reset while in WRITE aborts the write
    @(negedge clk);
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_address = 32'h010;
    req_wdata   = 32'hCAFEF00D;
    req_wstrb   = 4'hF;
    p0 = wr_pulses;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rw_in_write", {31'd0, ram_we}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rw_we_drop", {31'd0, ram_we}, 32'd0);
    chk("rw_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rw_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rw_idle", {31'd0, req_ready}, 32'd1);
    chk("rw_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("rw_no_pulse", wr_pulses - p0, 0);
    xact(1'b0, 32'h010, 32'h0, 4'h0, edges, rd, er, pulses);
    chk("rw_readback", rd, 32'hDEAA55EF);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
